// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master.
// Contents: FSM state enum, word addresses of the sysid slave, latency ceiling.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StLatId,
    StRdTs,
    StLatTs,
    StDone
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // The latency counter is 2 bits wide, so this is also the hard ceiling.
  localparam int unsigned MAX_READ_LATENCY = 3;

endpackage

// File: rtl/sysid_read_beat.sv
// Single Avalon-MM read engine, re-armed by the parent FSM for every word.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   start_i          arm a new read (strobe rises on the next cycle)
//   waitrequest_i    slave stall
//   read_o           read strobe (registered, held while stalled)
//   accept_o         read accepted this cycle
//   data_valid_o     slave read data is valid this cycle (one-cycle pulse)
//   timed_out_o      read abandoned this cycle (one-cycle pulse)
module sysid_read_beat
  import sysid_check_pkg::*;
#(
  parameter int unsigned ReadLatency   = 0,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic waitrequest_i,
  output logic read_o,
  output logic accept_o,
  output logic data_valid_o,
  output logic timed_out_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  // Last cycle a read may still be pending; the abort fires in this cycle.
  localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);
  localparam logic [1:0]      LatLast = 2'(ReadLatency - 1);

  logic            read_q, read_d;
  logic            lat_q, lat_d;
  logic [1:0]      lat_cnt_q, lat_cnt_d;
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign read_o = read_q;

  always_comb begin
    read_d       = read_q;
    lat_d        = lat_q;
    lat_cnt_d    = lat_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    accept_o     = read_q && !waitrequest_i;
    data_valid_o = 1'b0;
    timed_out_o  = 1'b0;

    if (start_i) begin
      read_d    = 1'b1;
      lat_d     = 1'b0;
      lat_cnt_d = '0;
      tmo_cnt_d = '0;
    end else if (read_q || lat_q) begin
      if (accept_o) begin
        read_d = 1'b0;
        if (ReadLatency == 0) begin
          data_valid_o = 1'b1;
        end else begin
          lat_d     = 1'b1;
          lat_cnt_d = '0;
        end
      end else if (lat_q) begin
        if (lat_cnt_q == LatLast) begin
          lat_d        = 1'b0;
          data_valid_o = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end

      // Data arriving in the final allowed cycle still counts as in time.
      if (!data_valid_o) begin
        if (tmo_cnt_q == TmoLast) begin
          timed_out_o = 1'b1;
          read_d      = 1'b0;
          lat_d       = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_q    <= 1'b0;
      lat_q     <= 1'b0;
      lat_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      read_q    <= read_d;
      lat_q     <= lat_d;
      lat_cnt_q <= lat_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them with build-time values for bring-up firmware and LEDs.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   start                   launch a check when idle or done
//   avm_*                   Avalon-MM read master towards the sysid slave
//   busy / done / pass      check status (pass valid while done)
//   id_match / ts_match     per-word compare results
//   timeout                 a read was abandoned
//   id_value / ts_value     captured words
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h1122_3344,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h56FD_1B26,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned Latency =
      (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

  state_e      state_q, state_d;
  logic        auto_q, auto_d;
  logic        ts_arm_q, ts_arm_d;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic        id_match_q, id_match_d, ts_match_q, ts_match_d;
  logic        timeout_q, timeout_d, pass_q, pass_d;
  logic        launch, beat_start, beat_accept, beat_valid, beat_timed_out;

  sysid_read_beat #(
    .ReadLatency  (Latency),
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_beat (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .start_i      (beat_start),
    .waitrequest_i(avm_waitrequest),
    .read_o       (avm_read),
    .accept_o     (beat_accept),
    .data_valid_o (beat_valid),
    .timed_out_o  (beat_timed_out)
  );

  always_comb begin
    state_d    = state_q;
    auto_d     = 1'b0;
    ts_arm_d   = 1'b0;
    id_d       = id_q;
    ts_d       = ts_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    launch     = 1'b0;
    beat_start = 1'b0;

    unique case (state_q)
      StIdle: launch = start || auto_q;
      StRdId, StLatId: begin
        if (beat_timed_out) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else if (beat_valid) begin
          id_d     = avm_readdata;
          state_d  = StRdTs;
          ts_arm_d = 1'b1;
        end else if (beat_accept) begin
          state_d = StLatId;
        end
      end
      StRdTs, StLatTs: begin
        // The first RD_TS cycle only re-arms the engine: this is the idle
        // gap between the two reads.
        beat_start = ts_arm_q;
        if (beat_timed_out) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else if (beat_valid) begin
          ts_d    = avm_readdata;
          state_d = StDone;
        end else if (beat_accept) begin
          state_d = StLatTs;
        end
      end
      StDone:  launch = start;
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d    = StRdId;
      beat_start = 1'b1;
      id_d       = '0;
      ts_d       = '0;
      id_match_d = 1'b0;
      ts_match_d = 1'b0;
      timeout_d  = 1'b0;
      pass_d     = 1'b0;
    end

    // Flags are registered on DONE entry so they are valid in its first cycle.
    if (state_d == StDone && state_q != StDone) begin
      id_match_d = (id_d == EXPECTED_ID);
      ts_match_d = (ts_d == EXPECTED_TIMESTAMP);
      pass_d     = id_match_d && ts_match_d && !timeout_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      auto_q     <= AUTO_START;
      ts_arm_q   <= 1'b0;
      id_q       <= '0;
      ts_q       <= '0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      ts_arm_q   <= ts_arm_d;
      id_q       <= id_d;
      ts_q       <= ts_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
    end
  end

  assign avm_address = (state_q == StRdTs || state_q == StLatTs) ? ADDR_TS : ADDR_ID;
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
  assign pass        = pass_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout     = timeout_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master using three instances:
//   a: defaults (latency 0, auto start), zero-wait slave
//   b: latency 2, no auto start, slave with programmable stall and latency pipe
//   c: latency 0, timeout 8, no auto start, slave with controllable waitrequest
module tb_sysid_check_master;

  localparam logic [31:0] ID = 32'h1122_3344;
  localparam logic [31:0] TS = 32'd1459428134;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance a
  logic        a_start, a_addr, a_read, a_wait, a_busy, a_done, a_pass;
  logic        a_idm, a_tsm, a_tmo;
  logic [31:0] a_rdata, a_idv, a_tsv, a_id_word;
  // Instance b
  logic        b_start, b_addr, b_read, b_wait, b_busy, b_done, b_pass;
  logic        b_idm, b_tsm, b_tmo;
  logic [31:0] b_rdata, b_idv, b_tsv;
  logic [2:0]  b_stall, b_stall_len;
  logic        b_p0, b_p1, b_a0, b_a1;
  // Instance c
  logic        c_start, c_addr, c_read, c_wait, c_busy, c_done, c_pass;
  logic        c_idm, c_tsm, c_tmo;
  logic [31:0] c_rdata, c_idv, c_tsv;

  assign a_wait  = 1'b0;
  assign a_rdata = a_addr ? TS : a_id_word;
  assign c_rdata = c_addr ? TS : ID;

  // Slave b: stalls each read for b_stall_len cycles, returns data 2 cycles after accept.
  assign b_wait  = b_read && (b_stall < b_stall_len);
  assign b_rdata = b_p1 ? (b_a1 ? TS : ID) : 32'hDEAD_BEEF;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_stall <= '0; b_p0 <= 1'b0; b_p1 <= 1'b0; b_a0 <= 1'b0; b_a1 <= 1'b0;
    end else begin
      if (b_read && b_wait) b_stall <= b_stall + 3'd1;
      else if (b_read) b_stall <= '0;
      b_p0 <= b_read && !b_wait;
      b_a0 <= b_addr;
      b_p1 <= b_p0;
      b_a1 <= b_a0;
    end
  end

  sysid_check_master u_dut_a (
    .clock(clk), .reset_n(rst_n), .start(a_start), .avm_address(a_addr), .avm_read(a_read),
    .avm_waitrequest(a_wait), .avm_readdata(a_rdata), .busy(a_busy), .done(a_done),
    .pass(a_pass), .id_match(a_idm), .ts_match(a_tsm), .timeout(a_tmo), .id_value(a_idv),
    .ts_value(a_tsv)
  );

  sysid_check_master #(
    .READ_LATENCY(2), .TIMEOUT_CYCLES(20), .AUTO_START(1'b0)
  ) u_dut_b (
    .clock(clk), .reset_n(rst_n), .start(b_start), .avm_address(b_addr), .avm_read(b_read),
    .avm_waitrequest(b_wait), .avm_readdata(b_rdata), .busy(b_busy), .done(b_done),
    .pass(b_pass), .id_match(b_idm), .ts_match(b_tsm), .timeout(b_tmo), .id_value(b_idv),
    .ts_value(b_tsv)
  );

  sysid_check_master #(
    .READ_LATENCY(0), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
  ) u_dut_c (
    .clock(clk), .reset_n(rst_n), .start(c_start), .avm_address(c_addr), .avm_read(c_read),
    .avm_waitrequest(c_wait), .avm_readdata(c_rdata), .busy(c_busy), .done(c_done),
    .pass(c_pass), .id_match(c_idm), .ts_match(c_tsm), .timeout(c_tmo), .id_value(c_idv),
    .ts_value(c_tsv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if ({a_busy, a_done, a_pass, a_read, a_addr, a_tmo} !== 6'b0)
      $display("FAIL reset_flags_a: got %b want 000000", {a_busy, a_done, a_pass, a_read, a_addr, a_tmo});
      else n_pass++;
    n_checks++; if ({a_idv, a_tsv} !== 64'h0)
      $display("FAIL reset_values_a: got %h want 0", {a_idv, a_tsv}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++; if (a_done !== (k == 4))
        $display("FAIL auto_done_k%0d: got %b want %b", k, a_done, (k == 4)); else n_pass++;
      if (k == 1) begin
        n_checks++; if ({a_read, a_addr} !== 2'b10)
          $display("FAIL auto_rd_id: got %b want 10", {a_read, a_addr}); else n_pass++;
      end
      if (k == 2) begin
        n_checks++; if (a_read !== 1'b0 || a_idv !== ID)
          $display("FAIL auto_gap: got read=%b id=%h want read=0 id=%h", a_read, a_idv, ID);
          else n_pass++;
      end
      if (k == 3) begin
        n_checks++; if ({a_read, a_addr, a_busy} !== 3'b111)
          $display("FAIL auto_rd_ts: got %b want 111", {a_read, a_addr, a_busy}); else n_pass++;
      end
    end
    n_checks++; if ({a_pass, a_idm, a_tsm, a_tmo, a_busy} !== 5'b11100)
      $display("FAIL auto_flags: got %b want 11100", {a_pass, a_idm, a_tsm, a_tmo, a_busy});
      else n_pass++;
    n_checks++; if (a_tsv !== TS)
      $display("FAIL auto_ts_value: got %h want %h", a_tsv, TS); else n_pass++;
    n_checks++; if (b_busy !== 1'b0 || b_read !== 1'b0)
      $display("FAIL no_auto_b: got busy=%b read=%b want 0 0", b_busy, b_read); else n_pass++;
  endtask

  task automatic test_id_mismatch();
    a_id_word = 32'h1122_3345;
    @(negedge clk); a_start = 1'b1;
    tick(); a_start = 1'b0;
    repeat (3) tick();
    n_checks++; if ({a_done, a_pass, a_idm, a_tsm} !== 4'b1001)
      $display("FAIL mismatch_flags: got %b want 1001", {a_done, a_pass, a_idm, a_tsm});
      else n_pass++;
    n_checks++; if (a_idv !== 32'h1122_3345)
      $display("FAIL mismatch_id_value: got %h want 11223345", a_idv); else n_pass++;
    a_id_word = ID;
  endtask

  task automatic test_start_while_busy();
    @(negedge clk); a_start = 1'b1;
    tick(); a_start = 1'b0;
    n_checks++; if ({a_done, a_busy, a_read} !== 3'b011)
      $display("FAIL restart_k1: got %b want 011", {a_done, a_busy, a_read}); else n_pass++;
    @(negedge clk); a_start = 1'b1;
    tick();
    tick(); a_start = 1'b0;
    n_checks++; if ({a_busy, a_read, a_addr} !== 3'b111)
      $display("FAIL busy_start_k3: got %b want 111", {a_busy, a_read, a_addr}); else n_pass++;
    tick();
    n_checks++; if ({a_done, a_pass, a_busy} !== 3'b110)
      $display("FAIL busy_start_k4: got %b want 110", {a_done, a_pass, a_busy}); else n_pass++;
    tick();
    n_checks++; if ({a_done, a_busy, a_read} !== 3'b100)
      $display("FAIL busy_start_k5: got %b want 100", {a_done, a_busy, a_read}); else n_pass++;
  endtask

  task automatic test_wait_latency();
    b_stall_len = 3'd5;
    @(negedge clk); b_start = 1'b1;
    tick(); b_start = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) tick();
      if (k <= 5) begin
        n_checks++; if ({b_read, b_addr} !== 2'b10)
          $display("FAIL stall_id_k%0d: got %b want 10", k, {b_read, b_addr}); else n_pass++;
      end
      if (k == 7) begin
        n_checks++; if (b_idv !== 32'h0)
          $display("FAIL lat_id_early: got %h want 0", b_idv); else n_pass++;
      end
      if (k == 8) begin
        n_checks++; if (b_idv !== ID || b_read !== 1'b0)
          $display("FAIL lat_id_cap: got id=%h read=%b want %h 0", b_idv, b_read, ID);
          else n_pass++;
      end
      if (k >= 9 && k <= 14) begin
        n_checks++; if ({b_read, b_addr} !== 2'b11)
          $display("FAIL stall_ts_k%0d: got %b want 11", k, {b_read, b_addr}); else n_pass++;
      end
      if (k == 16) begin
        n_checks++; if (b_tsv !== 32'h0 || {b_done, b_busy} !== 2'b01)
          $display("FAIL lat_ts_early: got ts=%h done/busy=%b want 0 01", b_tsv, {b_done, b_busy});
          else n_pass++;
      end
    end
    n_checks++; if (b_tsv !== TS)
      $display("FAIL lat_ts_cap: got %h want %h", b_tsv, TS); else n_pass++;
    n_checks++; if ({b_done, b_pass, b_tmo} !== 3'b110)
      $display("FAIL lat_flags: got %b want 110", {b_done, b_pass, b_tmo}); else n_pass++;
  endtask

  task automatic test_timeout();
    c_wait = 1'b1;
    @(negedge clk); c_start = 1'b1;
    tick(); c_start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      n_checks++; if (c_read !== (k < 8))
        $display("FAIL tmo_read_k%0d: got %b want %b", k, c_read, (k < 8)); else n_pass++;
    end
    n_checks++; if ({c_tmo, c_done, c_pass, c_busy, c_idm} !== 5'b11000)
      $display("FAIL tmo_flags: got %b want 11000", {c_tmo, c_done, c_pass, c_busy, c_idm});
      else n_pass++;
    n_checks++; if (c_idv !== 32'h0)
      $display("FAIL tmo_id_value: got %h want 0", c_idv); else n_pass++;
    c_wait = 1'b0;
    @(negedge clk); c_start = 1'b1;
    tick(); c_start = 1'b0;
    n_checks++; if ({c_done, c_tmo, c_busy} !== 3'b001)
      $display("FAIL tmo_restart: got %b want 001", {c_done, c_tmo, c_busy}); else n_pass++;
    repeat (3) tick();
    n_checks++; if ({c_done, c_pass, c_tmo} !== 3'b110)
      $display("FAIL tmo_recover: got %b want 110", {c_done, c_pass, c_tmo}); else n_pass++;
  endtask

  task automatic test_async_reset();
    b_stall_len = 3'd0;
    @(negedge clk); b_start = 1'b1;
    tick(); b_start = 1'b0;
    repeat (5) tick();
    n_checks++; if ({b_busy, b_read, b_addr} !== 3'b101 || b_idv !== ID)
      $display("FAIL lat_ts_state: got %b id=%h want 101 %h", {b_busy, b_read, b_addr}, b_idv, ID);
      else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b_busy, b_done, b_pass, b_read, b_addr, b_idm, b_tsm, b_tmo} !== 8'b0)
      $display("FAIL async_rst_flags: got %b want 00000000",
               {b_busy, b_done, b_pass, b_read, b_addr, b_idm, b_tsm, b_tmo});
      else n_pass++;
    n_checks++; if ({b_idv, b_tsv} !== 64'h0)
      $display("FAIL async_rst_values: got %h want 0", {b_idv, b_tsv}); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if ({b_busy, b_read, b_done} !== 3'b000)
      $display("FAIL stay_idle: got %b want 000", {b_busy, b_read, b_done}); else n_pass++;
    @(negedge clk); b_start = 1'b1;
    tick(); b_start = 1'b0;
    repeat (7) tick();
    n_checks++; if ({b_done, b_pass} !== 2'b11)
      $display("FAIL post_rst_check: got %b want 11", {b_done, b_pass}); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_id_word = ID; b_stall_len = 3'd0; c_wait = 1'b0;
    test_reset();
    test_id_mismatch();
    test_start_while_busy();
    test_wait_latency();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
